// File: rtl/idli_pkg.sv
// Shared types for the idli core: SQI period counter, 4b slices, 16b data words
// and the SQI arbiter state encoding.
package idli_pkg;

  localparam int unsigned CTR_W   = 2;
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned DATA_W  = 16;

  typedef logic [CTR_W-1:0]   ctr_t;
  typedef logic [SLICE_W-1:0] slice_t;
  typedef logic [DATA_W-1:0]  data_t;

  localparam ctr_t CTR_FIRST = 2'd0;
  localparam ctr_t CTR_LAST  = 2'd3;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    BR_REDIR  = 3'd1,
    LS_REDIR  = 3'd2,
    LS_WAIT   = 3'd3,
    LS_DATA   = 3'd4,
    RET_REDIR = 3'd5,
    RET_WAIT  = 3'd6
  } sqi_arb_state_t;

endpackage

// File: rtl/idli_sqi_arb_sreg_m.sv
// 16b little-endian serial-in/serial-out shift register: slices enter at the
// top and leave from the bottom, so the first slice in is the first slice out.
module idli_sqi_arb_sreg_m
  import idli_pkg::*;
(
  input  logic   gck_i,
  input  logic   rst_n_i,
  input  logic   en_i,
  input  slice_t slice_i,
  output slice_t slice_o
);

  data_t sreg_q;

  // Shift one slice per enabled GCK
  always_ff @(posedge gck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sreg_q <= '0;
    end else if (en_i) begin
      sreg_q <= {slice_i, sreg_q[DATA_W-1:SLICE_W]};
    end
  end

  assign slice_o = sreg_q[SLICE_W-1:0];

endmodule

// File: rtl/idli_sqi_arb_m.sv
// Shares the SQI memory port between streaming instruction fetch and the LSU.
// A request is taken at ctr==0 of a FETCH period and drives that same period
// as the redirect period, so the redirect outputs look ahead at the request.
module idli_sqi_arb_m
  import idli_pkg::*;
#(
  parameter int unsigned RD_WAIT = 5,
  parameter int unsigned WR_WAIT = 4
) (
  input  logic   i_sqi_gck,
  input  logic   i_sqi_rst_n,
  input  ctr_t   i_sqi_ctr,
  input  logic   i_arb_br_vld,
  input  slice_t i_arb_br_slice,
  input  logic   i_arb_ls_vld,
  input  logic   i_arb_ls_wr,
  input  slice_t i_arb_ls_slice,
  input  slice_t i_arb_st_slice,
  input  slice_t i_arb_pc_slice,
  output logic   o_arb_busy,
  output logic   o_arb_st_rdy,
  output logic   o_arb_ld_vld,
  output data_t  o_arb_ld_data,
  output logic   o_arb_instr_vld,
  output logic   o_arb_redirect,
  output logic   o_arb_wr_en,
  output slice_t o_arb_slice,
  input  data_t  i_arb_sqi_instr,
  input  logic   i_arb_sqi_instr_vld
);

  localparam int unsigned CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

  if (RD_WAIT == 0 || RD_WAIT > 7) begin : g_bad_rd_wait
    $error("RD_WAIT must be in 1..7");
  end
  if (WR_WAIT == 0 || WR_WAIT > 7) begin : g_bad_wr_wait
    $error("WR_WAIT must be in 1..7");
  end

  sqi_arb_state_t state_q;
  sqi_arb_state_t cur_state;
  cnt_t           cnt_q;
  logic           wr_q;
  logic           ld_vld_q;
  data_t          ld_data_q;
  logic           take_ls;
  logic           take_br;
  logic           ret_shift;
  slice_t         ret_in;
  slice_t         ret_slice;

  // Request acceptance; LS wins over a coincident branch
  always_comb begin
    take_ls   = (state_q == FETCH) && (i_sqi_ctr == CTR_FIRST) && i_arb_ls_vld;
    take_br   = (state_q == FETCH) && (i_sqi_ctr == CTR_FIRST) && i_arb_br_vld && !i_arb_ls_vld;
    cur_state = state_q;
    if (take_ls) begin
      cur_state = LS_REDIR;
    end else if (take_br) begin
      cur_state = BR_REDIR;
    end
  end

  // FSM, wait counter, store flag and load capture
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_data_q <= '0;
    end else begin
      ld_vld_q <= 1'b0;
      if (take_ls) begin
        wr_q <= i_arb_ls_wr;
      end
      case (state_q)
        FETCH: begin
          if (take_ls) begin
            state_q <= LS_REDIR;
          end else if (take_br) begin
            state_q <= BR_REDIR;
          end
        end
        BR_REDIR, RET_REDIR: begin
          if (i_sqi_ctr == CTR_LAST) begin
            state_q <= RET_WAIT;
            cnt_q   <= CNT_W'(RD_WAIT);
          end
        end
        LS_REDIR: begin
          if (i_sqi_ctr == CTR_LAST) begin
            state_q <= LS_WAIT;
            cnt_q   <= wr_q ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
          end
        end
        LS_WAIT, RET_WAIT: begin
          if (i_sqi_ctr == CTR_LAST) begin
            if (cnt_q == 3'd1) begin
              state_q <= (state_q == LS_WAIT) ? LS_DATA : FETCH;
            end
            if (cnt_q != 3'd0) begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        LS_DATA: begin
          if (i_sqi_ctr == CTR_LAST) begin
            state_q <= RET_REDIR;
            if (!wr_q) begin
              ld_data_q <= i_arb_sqi_instr;
              ld_vld_q  <= 1'b1;
            end
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Output mux driven from the look-ahead state
  always_comb begin
    o_arb_redirect  = 1'b0;
    o_arb_wr_en     = 1'b0;
    o_arb_slice     = '0;
    o_arb_st_rdy    = 1'b0;
    o_arb_instr_vld = 1'b0;
    ret_shift       = 1'b0;
    ret_in          = '0;
    case (cur_state)
      FETCH: o_arb_instr_vld = i_arb_sqi_instr_vld;
      BR_REDIR: begin
        o_arb_redirect = 1'b1;
        o_arb_slice    = i_arb_br_slice;
      end
      LS_REDIR: begin
        o_arb_redirect = 1'b1;
        o_arb_slice    = i_arb_ls_slice;
        o_arb_wr_en    = take_ls ? i_arb_ls_wr : wr_q;
        ret_shift      = 1'b1;
        ret_in         = i_arb_pc_slice;
      end
      LS_WAIT: begin
        o_arb_wr_en = wr_q;
        // Store data goes out in the last two wait periods, two GCKs per slice
        if (wr_q && cnt_q != 3'd0 && cnt_q <= 3'd2) begin
          o_arb_slice  = i_arb_st_slice;
          o_arb_st_rdy = i_sqi_ctr[0];
        end
      end
      LS_DATA: o_arb_wr_en = wr_q;
      RET_REDIR: begin
        o_arb_redirect = 1'b1;
        o_arb_slice    = ret_slice;
        ret_shift      = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_arb_busy    = (state_q != FETCH);
  assign o_arb_ld_vld  = ld_vld_q;
  assign o_arb_ld_data = ld_data_q;

  // Return PC: captured during LS_REDIR, replayed during RET_REDIR
  idli_sqi_arb_sreg_m u_ret_sreg (
    .gck_i   (i_sqi_gck),
    .rst_n_i (i_sqi_rst_n),
    .en_i    (ret_shift),
    .slice_i (ret_in),
    .slice_o (ret_slice)
  );

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Directed bench for the SQI arbiter: a table of transactions with hand-computed
// expectations, followed by reset-in-flight and memory-model checks.
module tb_idli_sqi_arb_m;
  import idli_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_BR   = 1;
  localparam int K_LD   = 2;
  localparam int K_ST   = 3;
  localparam int NPER   = 16;
  localparam int NVEC   = 6;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] wdata;
    bit          also_br;
    bit          busy_req;
    int          exp_busy;
    int          exp_redir_gcks;
    logic [15:0] exp_redir0;
    logic [15:0] exp_redir1;
    int          exp_ret_per;
    int          exp_wr_gcks;
    int          exp_st;
    logic [15:0] exp_st_word;
    int          exp_st_per;
    int          exp_ld;
    logic [15:0] exp_ld_data;
    int          exp_ld_at;
  } vec_t;

  logic   clk;
  logic   rst_n;
  ctr_t   ctr;
  logic   br_vld, ls_vld, ls_wr, sqi_vld;
  slice_t br_slice, ls_slice, st_slice, pc_slice;
  data_t  sqi_instr;
  logic   busy, st_rdy, ld_vld, instr_vld, redirect, wr_en;
  data_t  ld_data;
  slice_t slice;

  int n_chk;
  int n_pass;
  logic [15:0] mem [0:255];
  vec_t vecs [NVEC];

  idli_sqi_arb_m dut (
    .i_sqi_gck           (clk),
    .i_sqi_rst_n         (rst_n),
    .i_sqi_ctr           (ctr),
    .i_arb_br_vld        (br_vld),
    .i_arb_br_slice      (br_slice),
    .i_arb_ls_vld        (ls_vld),
    .i_arb_ls_wr         (ls_wr),
    .i_arb_ls_slice      (ls_slice),
    .i_arb_st_slice      (st_slice),
    .i_arb_pc_slice      (pc_slice),
    .o_arb_busy          (busy),
    .o_arb_st_rdy        (st_rdy),
    .o_arb_ld_vld        (ld_vld),
    .o_arb_ld_data       (ld_data),
    .o_arb_instr_vld     (instr_vld),
    .o_arb_redirect      (redirect),
    .o_arb_wr_en         (wr_en),
    .o_arb_slice         (slice),
    .i_arb_sqi_instr     (sqi_instr),
    .i_arb_sqi_instr_vld (sqi_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input int kind, input logic [15:0] addr, input logic [15:0] pc,
                              input logic [15:0] wdata, input bit also_br, input bit busy_req,
                              input int busy_p, input int rg, input logic [15:0] r0,
                              input logic [15:0] r1, input int ret_p, input int wrg,
                              input int st, input logic [15:0] stw, input int st_p,
                              input int ld, input logic [15:0] ldd, input int ld_at);
    vec_t v;
    v.kind = kind; v.addr = addr; v.pc = pc; v.wdata = wdata;
    v.also_br = also_br; v.busy_req = busy_req; v.exp_busy = busy_p;
    v.exp_redir_gcks = rg; v.exp_redir0 = r0; v.exp_redir1 = r1;
    v.exp_ret_per = ret_p; v.exp_wr_gcks = wrg; v.exp_st = st;
    v.exp_st_word = stw; v.exp_st_per = st_p; v.exp_ld = ld;
    v.exp_ld_data = ldd; v.exp_ld_at = ld_at;
    return v;
  endfunction

  task automatic idle_inputs();
    br_vld = 1'b0; ls_vld = 1'b0; ls_wr = 1'b0;
    br_slice = '0; ls_slice = '0; st_slice = '0; pc_slice = '0;
  endtask

  // Run one transaction over NPER periods; abort_at >= 0 stops after that GCK unchecked
  task automatic run_vec(input vec_t v, input int idx, input int abort_at);
    int busy_err, iv_err, rg, ret_per, wrg, st_n, st_per, ld_n, ld_at, first_iv;
    logic [15:0] r0, r1, stw, ldd, bt;
    logic exp_iv;
    string p;
    busy_err = 0; iv_err = 0; rg = 0; ret_per = -1; wrg = 0; st_n = 0; st_per = -1;
    ld_n = 0; ld_at = -1; first_iv = -1; r0 = '0; r1 = '0; stw = '0; ldd = '0;
    bt = (v.kind == K_BR) ? v.addr : 16'h5555;
    p = $sformatf("v%0d", idx);
    for (int k = 0; k < NPER; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        ctr       = 2'(c);
        sqi_vld   = (c == 3);
        sqi_instr = v.wdata;
        idle_inputs();
        if (k == 0) begin
          br_vld   = (v.kind == K_BR) || v.also_br;
          br_slice = bt[4*c +: 4];
          ls_vld   = (v.kind == K_LD) || (v.kind == K_ST);
          ls_wr    = (v.kind == K_ST);
          ls_slice = v.addr[4*c +: 4];
          pc_slice = v.pc[4*c +: 4];
        end else if (v.busy_req && k < v.exp_busy) begin
          br_vld = 1'b1; br_slice = 4'hF;
          ls_vld = 1'b1; ls_wr = 1'b1; ls_slice = 4'hE; pc_slice = 4'h9;
        end
        if (st_n < 4) st_slice = v.wdata[4*st_n +: 4];
        @(negedge clk);
        if (k == 0 && c == 0 && busy !== 1'b0) busy_err++;
        if (c == 2 && busy !== 1'(k < v.exp_busy)) busy_err++;
        if (redirect) begin
          rg++;
          if (k == 0) r0[4*c +: 4] = slice;
          else begin
            r1[4*c +: 4] = slice;
            if (ret_per < 0) ret_per = k;
          end
        end
        if (wr_en) wrg++;
        if (st_rdy) begin
          if (st_per < 0) st_per = k;
          if (st_n < 4) stw[4*st_n +: 4] = slice;
          st_n++;
        end
        if (ld_vld) begin
          ld_n++;
          ldd = ld_data;
          if (ld_at < 0) ld_at = k * 4 + c;
        end
        exp_iv = sqi_vld && (k >= v.exp_busy);
        if (instr_vld !== exp_iv) iv_err++;
        if (instr_vld && first_iv < 0) first_iv = k;
        if (abort_at == k * 4 + c) return;
      end
    end
    chk({p, " busy window"}, busy_err, 0);
    chk({p, " instr_vld gating"}, iv_err, 0);
    chk({p, " first instr_vld period"}, first_iv, v.exp_busy);
    chk({p, " redirect gcks"}, rg, v.exp_redir_gcks);
    chk({p, " redirect slices"}, r0, v.exp_redir0);
    chk({p, " return slices"}, r1, v.exp_redir1);
    chk({p, " return period"}, ret_per, v.exp_ret_per);
    chk({p, " wr_en gcks"}, wrg, v.exp_wr_gcks);
    chk({p, " st_rdy pulses"}, st_n, v.exp_st);
    chk({p, " ld_vld pulses"}, ld_n, v.exp_ld);
    chk({p, " ld_vld time"}, ld_at, v.exp_ld_at);
    if (v.exp_st > 0) begin
      chk({p, " store word"}, stw, v.exp_st_word);
      chk({p, " st_rdy period"}, st_per, v.exp_st_per);
    end
    if (v.exp_ld > 0) chk({p, " ld_data"}, ldd, v.exp_ld_data);
    if (wrg > 0 && st_n == 4) mem[r0[7:0]] = stw;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    //            kind  addr      pc        wdata     br bq bsy rg  redir0    redir1    ret wr st stw      stp ld ldd      ldat
    vecs[0] = mk(K_NONE, 16'h0000, 16'h0000, 16'h0000, 0, 0,  0, 0, 16'h0000, 16'h0000, -1,  0, 0, 16'h0000, -1, 0, 16'h0000, -1);
    vecs[1] = mk(K_BR,   16'h1234, 16'h0000, 16'h0000, 0, 0,  6, 4, 16'h1234, 16'h0000, -1,  0, 0, 16'h0000, -1, 0, 16'h0000, -1);
    vecs[2] = mk(K_LD,   16'h0040, 16'h0102, 16'hBEEF, 0, 0, 13, 8, 16'h0040, 16'h0102,  7,  0, 0, 16'h0000, -1, 1, 16'hBEEF, 28);
    vecs[3] = mk(K_ST,   16'h0010, 16'h0200, 16'hA5C3, 0, 1, 12, 8, 16'h0010, 16'h0200,  6, 24, 4, 16'hA5C3,  3, 0, 16'h0000, -1);
    vecs[4] = mk(K_LD,   16'hFFFE, 16'hFFFF, 16'h0001, 1, 0, 13, 8, 16'hFFFE, 16'hFFFF,  7,  0, 0, 16'h0000, -1, 1, 16'h0001, 28);
    vecs[5] = mk(K_BR,   16'h0000, 16'h0000, 16'h0000, 0, 1,  6, 4, 16'h0000, 16'h0000, -1,  0, 0, 16'h0000, -1, 0, 16'h0000, -1);

    rst_n = 1'b0; ctr = '0; sqi_vld = 1'b0; sqi_instr = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset redirect", redirect, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset st_rdy", st_rdy, 0);
    chk("reset ld_vld", ld_vld, 0);
    chk("reset slice", slice, 0);
    chk("reset ld_data", ld_data, 0);
    sqi_vld = 1'b1; #1;
    chk("reset instr_vld follows 1", instr_vld, 1);
    sqi_vld = 1'b0; #1;
    chk("reset instr_vld follows 0", instr_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i, -1);
    chk("memory[0x0010] after store", mem[8'h10], 16'hA5C3);

    // Reset in LS_WAIT while store data is being pushed (period 3, ctr 1)
    run_vec(mk(K_ST, 16'h0020, 16'h0345, 16'h5A3C, 0, 0, 12, 8, 16'h0020, 16'h0345, 6, 24, 4,
               16'h5A3C, 3, 0, 16'h0000, -1), 6, 13);
    chk("pre-reset st_rdy", st_rdy, 1);
    chk("pre-reset wr_en", wr_en, 1);
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset wr_en", wr_en, 0);
    chk("mid reset st_rdy", st_rdy, 0);
    chk("mid reset slice", slice, 0);
    chk("mid reset redirect", redirect, 0);
    chk("mid reset ld_data", ld_data, 0);
    chk("mid reset ret reg", dut.u_ret_sreg.sreg_q, 0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 7, -1);
    run_vec(vecs[1], 8, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
